// File: rtl/instruction_decode.sv
// Instruction decode stage: 32x32 register file with combinational reads,
// opcode/funct control decode, and immediate extension.
module instruction_decode (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic [31:0] Instruction,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] Imm32,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic        Jump,
  output logic [3:0]  ALUCtrl,
  output logic        Illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  waddr;
  logic        wen;
  logic [31:0] regs [32];

  assign opcode = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign rd     = Instruction[15:11];
  assign funct  = Instruction[5:0];

  // ori is the only zero-extending opcode; everything else replicates bit 15
  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zero_ext);
    logic signed [15:0] simm;
    simm = signed'(imm);
    if (zero_ext) ext_imm = {16'h0000, imm};
    else          ext_imm = 32'(simm);
  endfunction

  assign Imm32 = ext_imm(Instruction[15:0], opcode == OP_ORI);

  // R-type writes rd, every other writing opcode writes rt; $0 is never written
  assign waddr = (opcode == OP_RTYPE) ? rd : rt;
  assign wen   = Run && RegWrite && (waddr != 5'd0);

  // Reads see the pre-edge contents (no bypass); $0 is hard-wired to zero
  assign ReadData1 = (rs == 5'd0) ? 32'h0 : regs[rs];
  assign ReadData2 = (rt == 5'd0) ? 32'h0 : regs[rt];

  // Register file: reset clears every entry and wins over a simultaneous write
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (wen) begin
      regs[waddr] <= WriteData;
    end
  end

  // Control decode, purely from Instruction; unsupported encodings leave all controls at NOP
  always_comb begin
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    ALUCtrl  = 4'b0000;
    Illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        // The all-zero word (sll $0,$0,0) is the canonical NOP
        if (Instruction != 32'h0) begin
          case (funct)
            FN_ADD:  begin RegWrite = 1'b1; ALUCtrl = 4'b0010; end
            FN_SUB:  begin RegWrite = 1'b1; ALUCtrl = 4'b0110; end
            FN_AND:  begin RegWrite = 1'b1; ALUCtrl = 4'b0000; end
            FN_OR:   begin RegWrite = 1'b1; ALUCtrl = 4'b0001; end
            FN_SLT:  begin RegWrite = 1'b1; ALUCtrl = 4'b0111; end
            default: Illegal = 1'b1;
          endcase
        end
      end
      OP_LW: begin
        RegWrite = 1'b1; ALUSrc = 1'b1; MemtoReg = 1'b1; MemRead = 1'b1;
        ALUCtrl  = 4'b0010;
      end
      OP_SW: begin
        ALUSrc = 1'b1; MemWrite = 1'b1; ALUCtrl = 4'b0010;
      end
      OP_BEQ: begin
        Branch = 1'b1; ALUCtrl = 4'b0110;
      end
      OP_J: begin
        Jump = 1'b1;
      end
      OP_ADDI: begin
        RegWrite = 1'b1; ALUSrc = 1'b1; ALUCtrl = 4'b0010;
      end
      OP_ORI: begin
        RegWrite = 1'b1; ALUSrc = 1'b1; ALUCtrl = 4'b0001;
      end
      default: Illegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode table plus register-file sequences.
module tb_instruction_decode;

  logic        Clk;
  logic        Reset;
  logic        Run;
  logic [31:0] Instruction;
  logic [31:0] WriteData;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] Imm32;
  logic        ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump;
  logic [3:0]  ALUCtrl;
  logic        Illegal;

  int nchecks = 0;
  int npass   = 0;

  instruction_decode dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Instruction(Instruction),
    .WriteData(WriteData), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Imm32(Imm32), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
    .ALUCtrl(ALUCtrl), .Illegal(Illegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ctrl bit order: RegWrite ALUSrc MemtoReg MemRead MemWrite Branch Jump
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [6:0]  ctrl;
    logic [3:0]  alu;
    logic        ill;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present an R-type add that reads rs/rt without ticking
  task automatic rd_regs(input logic [4:0] a, input logic [4:0] b);
    Instruction = {6'h00, a, b, 5'd0, 5'd0, 6'h20};
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"add",      32'h00221820, 7'b1000000, 4'b0010, 1'b0, 32'h00001820};
    vecs[1]  = '{"sub",      32'h00221822, 7'b1000000, 4'b0110, 1'b0, 32'h00001822};
    vecs[2]  = '{"and",      32'h00221824, 7'b1000000, 4'b0000, 1'b0, 32'h00001824};
    vecs[3]  = '{"or",       32'h00221825, 7'b1000000, 4'b0001, 1'b0, 32'h00001825};
    vecs[4]  = '{"slt",      32'h0022182A, 7'b1000000, 4'b0111, 1'b0, 32'h0000182A};
    vecs[5]  = '{"lw",       32'h8C23FFFC, 7'b1111000, 4'b0010, 1'b0, 32'hFFFFFFFC};
    vecs[6]  = '{"sw",       32'hAC23FFF0, 7'b0100100, 4'b0010, 1'b0, 32'hFFFFFFF0};
    vecs[7]  = '{"beq",      32'h10220003, 7'b0000010, 4'b0110, 1'b0, 32'h00000003};
    vecs[8]  = '{"j",        32'h08000010, 7'b0000001, 4'b0000, 1'b0, 32'h00000010};
    vecs[9]  = '{"addi",     32'h2001000A, 7'b1100000, 4'b0010, 1'b0, 32'h0000000A};
    vecs[10] = '{"addi_neg", 32'h2001FFFF, 7'b1100000, 4'b0010, 1'b0, 32'hFFFFFFFF};
    vecs[11] = '{"ori",      32'h3402FFFF, 7'b1100000, 4'b0001, 1'b0, 32'h0000FFFF};
    vecs[12] = '{"ill_op",   32'hFC000000, 7'b0000000, 4'b0000, 1'b1, 32'h00000000};
    vecs[13] = '{"nop",      32'h00000000, 7'b0000000, 4'b0000, 1'b0, 32'h00000000};
    vecs[14] = '{"ill_fn",   32'h00221821, 7'b0000000, 4'b0000, 1'b1, 32'h00001821};
    vecs[15] = '{"sll_nz",   32'h00021080, 7'b0000000, 4'b0000, 1'b1, 32'h00001080};

    Reset = 1'b1; Run = 1'b0; Instruction = 32'h0; WriteData = 32'h0;
    tick();
    Reset = 1'b0;

    // Reset state and first decode
    Instruction = 32'h00221820; #1;
    check("rst_rd1", 64'(ReadData1), 64'h0);
    check("rst_rd2", 64'(ReadData2), 64'h0);
    check("rst_add_ctl", 64'({RegWrite, Illegal, ALUCtrl}), 64'({1'b1, 1'b0, 4'b0010}));

    // Decode table with Run low so nothing is written
    for (int i = 0; i < 16; i++) begin
      Instruction = vecs[i].instr;
      #1;
      check({"dec_", vecs[i].name},
            {RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite, Branch, Jump, ALUCtrl, Illegal, Imm32},
            64'({vecs[i].ctrl, vecs[i].alu, vecs[i].ill, vecs[i].imm}));
      #1;
    end

    // addi $1,$0,10: no bypass before the edge, visible after
    Run = 1'b1; Instruction = 32'h2001000A; WriteData = 32'd10; #1;
    check("no_bypass", 64'(ReadData2), 64'h0);
    tick();
    Instruction = 32'h00200820; #1;
    check("addi_wr", 64'(ReadData1), 64'h0000000A);

    // ori $2,$0,0xFFFF
    Instruction = 32'h3402FFFF; WriteData = 32'h0000FFFF;
    tick();
    rd_regs(5'd1, 5'd2);
    check("r1_after_ori", 64'(ReadData1), 64'h0000000A);
    check("r2_after_ori", 64'(ReadData2), 64'h0000FFFF);

    // Writes to $0 are discarded
    Instruction = 32'h20000005; WriteData = 32'd5;
    tick();
    rd_regs(5'd0, 5'd0);
    check("r0_zero", 64'(ReadData1), 64'h0);

    // Run=0 blocks the write to $4, then Run=1 lets it through
    Run = 1'b0; Instruction = 32'h20040007; WriteData = 32'd7;
    tick();
    rd_regs(5'd4, 5'd0);
    check("run0_block", 64'(ReadData1), 64'h0);
    Run = 1'b1; Instruction = 32'h20040007;
    tick();
    rd_regs(5'd4, 5'd0);
    check("run1_write", 64'(ReadData1), 64'h7);

    // R-type writes rd ($3), not rt ($2)
    Instruction = 32'h00221820; WriteData = 32'h00001234;
    tick();
    rd_regs(5'd3, 5'd2);
    check("rtype_rd", 64'(ReadData1), 64'h00001234);
    check("rtype_rt_kept", 64'(ReadData2), 64'h0000FFFF);

    // Illegal opcode targeting rt=$1 and illegal funct targeting rd=$3 change nothing
    Instruction = 32'hFC010000; WriteData = 32'h0000DEAD; #1;
    check("ill_ctl", 64'({RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite, Branch, Jump, ALUCtrl, Illegal}),
          64'({7'b0, 4'b0, 1'b1}));
    tick();
    Instruction = 32'h00221821; WriteData = 32'h0000BEEF;
    tick();
    rd_regs(5'd1, 5'd3);
    check("ill_op_nowr", 64'(ReadData1), 64'h0000000A);
    check("ill_fn_nowr", 64'(ReadData2), 64'h00001234);

    // Reset overrides a simultaneous write; decode still follows Instruction
    Reset = 1'b1; Instruction = 32'h2001000A; WriteData = 32'h00000055; #1;
    check("rst_comb", 64'({RegWrite, ALUSrc, ALUCtrl}), 64'({1'b1, 1'b1, 4'b0010}));
    tick();
    Reset = 1'b0; Run = 1'b0;
    rd_regs(5'd1, 5'd3);
    check("rst_r1", 64'(ReadData1), 64'h0);
    check("rst_r3", 64'(ReadData2), 64'h0);
    rd_regs(5'd4, 5'd2);
    check("rst_r4", 64'(ReadData1), 64'h0);
    check("rst_r2", 64'(ReadData2), 64'h0);

    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
